// File: rtl/param_datapath.sv
// -----------------------------------------------------------------------------
// param_datapath
//
// Parametrised register-file datapath with its own micro-step sequencer.
// One start pulse runs a complete three-register operation:
//   op 0 ADD  R[rc] <- R[ra] + R[rb]
//   op 1 SUB  R[rc] <- R[ra] - R[rb]
//   op 2 AND  R[rc] <- R[ra] & R[rb]
//   op 3 MFLO R[rc] <- LO
//   op 4 MUL  {HI,LO} <- R[ra] * R[rb]   (unsigned, iterative shift-add)
//   op 5 LD   R[rc] <- mem[R[ra] + R[rb]]
//   op 6 ST   mem[R[ra] + R[rb]] <- R[rc]
//   op 7 MFHI R[rc] <- HI
// R0 always reads as zero and writes to it are dropped.
//
// Ports
//   clock, clear      : rising-edge clock, asynchronous active-low reset
//   start, op, ra,
//   rb, rc            : operation request; sampled only in IDLE, then latched
//   busy, done, err   : status; done/err are single-cycle pulses
//   mem_*             : memory request/acknowledge interface
//   dbg_sel/dbg_data  : combinational register file peek
//   dbg_state         : current sequencer state
//
// Handshakes
//   start is a one-shot request: it is accepted on the first rising edge in
//   IDLE where it is high, and ignored in every other state (no queueing).
//   mem_rd / mem_wr are held high with mem_addr / mem_wdata stable until a
//   rising edge samples mem_ack high; the transfer completes on that edge.
//   If MEM_TIMEOUT request cycles pass without mem_ack the request is dropped
//   and the operation finishes with err. mem_ack outside MEM is ignored.
// -----------------------------------------------------------------------------
module param_datapath #(
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 16,
   parameter int REG_AW      = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [REG_AW-1:0] ra,
   input  logic [REG_AW-1:0] rb,
   input  logic [REG_AW-1:0] rc,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [REG_AW-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_data,
   output logic [2:0]        dbg_state
);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_MFLO = 3'd3;
   localparam logic [2:0] OP_MUL  = 3'd4;
   localparam logic [2:0] OP_LD   = 3'd5;
   localparam logic [2:0] OP_ST   = 3'd6;
   localparam logic [2:0] OP_MFHI = 3'd7;

   // Timeout counter holds 0..MEM_TIMEOUT-1; multiply step counter 0..DATA_W.
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam int MW = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LDY  = 3'd1,
      S_EXE  = 3'd2,
      S_MUL  = 3'd3,
      S_WB   = 3'd4,
      S_MAR  = 3'd5,
      S_MEM  = 3'd6,
      S_DONE = 3'd7
   } state_e;

   state_e              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [REG_AW-1:0]   ra_q, ra_d;
   logic [REG_AW-1:0]   rb_q, rb_d;
   logic [REG_AW-1:0]   rc_q, rc_d;
   logic [DATA_W-1:0]   y_q, y_d;
   logic [2*DATA_W-1:0] z_q, z_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic [DATA_W-1:0]   mar_q, mar_d;
   logic [DATA_W-1:0]   mdr_q, mdr_d;
   logic [TW-1:0]       tcnt_q, tcnt_d;
   logic [MW-1:0]       mcnt_q, mcnt_d;
   logic                abort_q, abort_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];

   // Register file read ports; R0 is forced to zero at every read.
   logic [DATA_W-1:0] src_a, src_b, src_c;
   assign src_a    = (ra_q == '0)    ? '0 : regs_q[ra_q];
   assign src_b    = (rb_q == '0)    ? '0 : regs_q[rb_q];
   assign src_c    = (rc_q == '0)    ? '0 : regs_q[rc_q];
   assign dbg_data = (dbg_sel == '0) ? '0 : regs_q[dbg_sel];

   logic is_mem_op;
   assign is_mem_op = (op_q == OP_LD) || (op_q == OP_ST);

   // One shift-add step: Z holds {partial product, remaining multiplier}.
   // The low bit of Z selects whether Y is added into the upper half; the
   // carry out of that add becomes the new top bit after the right shift.
   logic [DATA_W:0] mul_sum;
   assign mul_sum = {1'b0, z_q[2*DATA_W-1:DATA_W]} + (z_q[0] ? {1'b0, y_q} : '0);

   logic mem_last;
   assign mem_last = (tcnt_q == TW'(MEM_TIMEOUT - 1));

   // ---------------------------------------------------------------------------
   // Sequencer: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Sequencer: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_LDY;
         S_LDY:  state_d = (op_q == OP_MUL) ? S_MUL : S_EXE;
         S_EXE:  state_d = is_mem_op ? S_MAR : S_WB;
         // Cycle with mcnt 0 loads the multiplier, cycles 1..DATA_W iterate.
         S_MUL:  if (mcnt_q == MW'(DATA_W)) state_d = S_WB;
         S_WB:   state_d = S_DONE;
         S_MAR:  state_d = S_MEM;
         S_MEM: begin
            // An ack on the final allowed cycle still wins over the timeout.
            if (mem_ack)       state_d = (op_q == OP_LD) ? S_WB : S_DONE;
            else if (mem_last) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Sequencer: outputs (all decoded from state so reset clears them at once)
   // ---------------------------------------------------------------------------
   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      err       = (state_q == S_DONE) && abort_q;
      mem_rd    = (state_q == S_MEM) && (op_q == OP_LD);
      mem_wr    = (state_q == S_MEM) && (op_q == OP_ST);
      dbg_state = state_q;
   end

   assign mem_addr  = mar_q;
   assign mem_wdata = mdr_q;

   // ---------------------------------------------------------------------------
   // Datapath next-value logic
   // ---------------------------------------------------------------------------
   always_comb begin
      op_d    = op_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rc_d    = rc_q;
      y_d     = y_q;
      z_d     = z_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      tcnt_d  = tcnt_q;
      mcnt_d  = mcnt_q;
      abort_d = abort_q;
      regs_d  = regs_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               ra_d    = ra;
               rb_d    = rb;
               rc_d    = rc;
               abort_d = 1'b0;
            end
         end

         S_LDY: begin
            y_d    = src_a;
            mcnt_d = '0;
         end

         S_EXE: begin
            // LD/ST reuse the adder for address generation.
            case (op_q)
               OP_SUB:  z_d = {{DATA_W{1'b0}}, y_q - src_b};
               OP_AND:  z_d = {{DATA_W{1'b0}}, y_q & src_b};
               OP_MFLO: z_d = {{DATA_W{1'b0}}, lo_q};
               OP_MFHI: z_d = {{DATA_W{1'b0}}, hi_q};
               default: z_d = {{DATA_W{1'b0}}, y_q + src_b};
            endcase
         end

         S_MUL: begin
            if (mcnt_q == '0) begin
               z_d = {{DATA_W{1'b0}}, src_b};
            end else begin
               z_d = {mul_sum, z_q[DATA_W-1:1]};
            end
            mcnt_d = mcnt_q + MW'(1);
         end

         S_MAR: begin
            mar_d  = z_q[DATA_W-1:0];
            tcnt_d = '0;
            if (op_q == OP_ST) mdr_d = src_c;
         end

         S_MEM: begin
            if (mem_ack) begin
               if (op_q == OP_LD) mdr_d = mem_rdata;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
               if (mem_last) abort_d = 1'b1;
            end
         end

         S_WB: begin
            if (op_q == OP_MUL) begin
               hi_d = z_q[2*DATA_W-1:DATA_W];
               lo_d = z_q[DATA_W-1:0];
            end else if (rc_q != '0) begin
               regs_d[rc_q] = (op_q == OP_LD) ? mdr_q : z_q[DATA_W-1:0];
            end
         end

         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         op_q    <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         rc_q    <= '0;
         y_q     <= '0;
         z_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         mar_q   <= '0;
         mdr_q   <= '0;
         tcnt_q  <= '0;
         mcnt_q  <= '0;
         abort_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         op_q    <= op_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rc_q    <= rc_d;
         y_q     <= y_d;
         z_q     <= z_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         tcnt_q  <= tcnt_d;
         mcnt_q  <= mcnt_d;
         abort_q <= abort_d;
         regs_q  <= regs_d;
      end
   end

endmodule

// File: tb/tb_param_datapath.sv
// -----------------------------------------------------------------------------
// tb_param_datapath
//
// Self-checking bench for param_datapath (DATA_W 32, 16 registers, timeout 15).
// A behavioural model (register array, HI/LO, associative memory) predicts
// every result and latency from the operation semantics; the memory responder
// serves reads from the same model memory and acks on a chosen request cycle.
// -----------------------------------------------------------------------------
module tb_param_datapath;

   localparam int DATA_W = 32;
   localparam int NUM_REGS = 16;
   localparam int REG_AW = 4;
   localparam int MEM_TIMEOUT = 15;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_MFLO = 3'd3;
   localparam logic [2:0] OP_MUL  = 3'd4;
   localparam logic [2:0] OP_LD   = 3'd5;
   localparam logic [2:0] OP_ST   = 3'd6;
   localparam logic [2:0] OP_MFHI = 3'd7;

   // ---------------------------------------------------------------- clock/reset
   logic              clock = 1'b0;
   logic              clear;
   logic              start;
   logic [2:0]        op;
   logic [REG_AW-1:0] ra, rb, rc;
   logic              busy, done, err;
   logic [DATA_W-1:0] mem_addr, mem_wdata;
   logic              mem_rd, mem_wr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic [REG_AW-1:0] dbg_sel;
   logic [DATA_W-1:0] dbg_data;
   logic [2:0]        dbg_state;

   initial forever #5 clock = ~clock;

   param_datapath #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
      .busy(busy), .done(done), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_state(dbg_state)
   );

   // ---------------------------------------------------------------- model
   logic [31:0] m_regs [16];
   logic [31:0] m_hi, m_lo;
   logic [31:0] m_mem [logic [31:0]];
   int checks = 0;
   int errors = 0;

   // Observations from the last run_op.
   int obs_lat, obs_req, obs_bad, obs_stray;
   bit obs_err, obs_busy_after;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_hi = '0;
      m_lo = '0;
   endtask

   // Predicts the effect of one operation. k is the request cycle on which
   // memory acks (0 = never). Returns expected latency, err, address, wdata.
   task automatic model_exec(input logic [2:0] o, input logic [3:0] a, b, c, input int k,
                             output int lat, output bit e_err,
                             output logic [31:0] e_addr, output logic [31:0] e_wdata);
      logic [31:0] av, bv, res;
      logic [63:0] prod;
      bit ok, wr;
      av = m_regs[a];
      bv = m_regs[b];
      e_wdata = m_regs[c];
      e_addr = av + bv;
      ok = (k >= 1) && (k <= MEM_TIMEOUT);
      e_err = 1'b0;
      wr = 1'b1;
      res = '0;
      lat = 4;
      case (o)
         OP_ADD:  res = av + bv;
         OP_SUB:  res = av - bv;
         OP_AND:  res = av & bv;
         OP_MFLO: res = m_lo;
         OP_MFHI: res = m_hi;
         OP_MUL: begin
            prod = {32'b0, av} * {32'b0, bv};
            m_hi = prod[63:32];
            m_lo = prod[31:0];
            wr = 1'b0;
            lat = DATA_W + 4;
         end
         OP_LD: begin
            lat = ok ? 5 + k : 4 + MEM_TIMEOUT;
            e_err = !ok;
            wr = ok;
            if (ok) begin
               if (!m_mem.exists(e_addr)) m_mem[e_addr] = $urandom;
               res = m_mem[e_addr];
            end
         end
         default: begin
            lat = ok ? 4 + k : 4 + MEM_TIMEOUT;
            e_err = !ok;
            wr = 1'b0;
            if (ok) m_mem[e_addr] = e_wdata;
         end
      endcase
      if (wr && c != 4'd0) m_regs[c] = res;
   endtask

   // ---------------------------------------------------------------- driver
   // Issues one operation, scrambles the inputs after acceptance, toggles
   // start randomly while busy (and high during DONE), and plays memory.
   task automatic run_op(input logic [2:0] o, input logic [3:0] a, b, c, input int k,
                         input logic [31:0] ea, input logic [31:0] ew);
      int n;
      bit got;
      obs_lat = -1; obs_err = 1'b0; obs_req = 0; obs_bad = 0; obs_stray = 0;
      obs_busy_after = 1'b1;
      @(negedge clock);
      start = 1'b1; op = o; ra = a; rb = b; rc = c;
      @(posedge clock); #1;
      start = 1'b0; op = 3'($urandom); ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      n = 1;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clock);
         if (done) begin
            got = 1'b1;
            obs_lat = n;
            obs_err = err;
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            obs_busy_after = busy;
         end else begin
            if (err) obs_stray++;
            start = 1'($urandom);
            if (mem_rd || mem_wr) begin
               obs_req++;
               if (mem_addr !== ea || (mem_wr && mem_wdata !== ew) ||
                   (mem_rd && o != OP_LD) || (mem_wr && o != OP_ST)) obs_bad++;
               if (obs_req == k) begin
                  mem_ack = 1'b1;
                  mem_rdata = m_mem.exists(mem_addr) ? m_mem[mem_addr] : 32'hDEAD_BEEF;
               end
            end
            @(posedge clock); #1;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            n++;
         end
      end
      start = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL watchdog: done not seen within %0d edges for op %0d", n, o);
      end
   endtask

   task automatic preload(input logic [3:0] r, input logic [31:0] v);
      int lat; bit e; logic [31:0] ea, ew;
      m_mem[32'h0] = v;
      model_exec(OP_LD, 4'd0, 4'd0, r, 1, lat, e, ea, ew);
      run_op(OP_LD, 4'd0, 4'd0, r, 1, ea, ew);
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      int bad;
      clear = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++;
      if ({busy, done, err, mem_rd, mem_wr} !== 5'b0 || dbg_state !== 3'd0) begin
         errors++;
         $display("FAIL reset_status: busy/done/err/rd/wr=%b state=%0d want 00000 0",
                  {busy, done, err, mem_rd, mem_wr}, dbg_state);
      end
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i); #1;
         if (dbg_data !== 32'h0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_regs: %0d registers nonzero, want 0", bad);
      end
      @(negedge clock);
      clear = 1'b1;
      model_reset();
   endtask

   task automatic test_alu();
      int lat; bit e; logic [31:0] ea, ew;
      preload(4'd1, 32'hFFFF_FFFF);
      preload(4'd2, 32'h0000_0002);
      model_exec(OP_ADD, 4'd1, 4'd2, 4'd3, 0, lat, e, ea, ew);
      run_op(OP_ADD, 4'd1, 4'd2, 4'd3, 0, ea, ew);
      checks++;
      if (obs_lat !== 4 || obs_busy_after !== 1'b0) begin
         errors++;
         $display("FAIL add_timing: latency %0d busy_after %b want 4 0", obs_lat, obs_busy_after);
      end
      dbg_sel = 4'd3; #1;
      checks++;
      if (dbg_data !== 32'h0000_0001) begin
         errors++;
         $display("FAIL add_result: R3=%h want 00000001", dbg_data);
      end
      model_exec(OP_SUB, 4'd2, 4'd1, 4'd4, 0, lat, e, ea, ew);
      run_op(OP_SUB, 4'd2, 4'd1, 4'd4, 0, ea, ew);
      dbg_sel = 4'd4; #1;
      checks++;
      if (dbg_data !== 32'h0000_0003 || obs_lat !== 4) begin
         errors++;
         $display("FAIL sub_result: R4=%h latency %0d want 00000003 4", dbg_data, obs_lat);
      end
      model_exec(OP_AND, 4'd1, 4'd1, 4'd1, 0, lat, e, ea, ew);
      run_op(OP_AND, 4'd1, 4'd1, 4'd1, 0, ea, ew);
      dbg_sel = 4'd1; #1;
      checks++;
      if (dbg_data !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL and_same_reg: R1=%h want ffffffff", dbg_data);
      end
   endtask

   task automatic test_r0();
      int lat; bit e; logic [31:0] ea, ew, v;
      v = $urandom | 32'h1;
      preload(4'd1, v);
      model_exec(OP_ADD, 4'd1, 4'd1, 4'd0, 0, lat, e, ea, ew);
      run_op(OP_ADD, 4'd1, 4'd1, 4'd0, 0, ea, ew);
      dbg_sel = 4'd0; #1;
      checks++;
      if (dbg_data !== 32'h0 || obs_lat !== 4) begin
         errors++;
         $display("FAIL r0_write: R0=%h latency %0d want 0 4", dbg_data, obs_lat);
      end
      preload(4'd0, 32'h1234_5678);
      dbg_sel = 4'd0; #1;
      checks++;
      if (dbg_data !== 32'h0) begin
         errors++;
         $display("FAIL r0_load: R0=%h want 0", dbg_data);
      end
      model_exec(OP_ADD, 4'd0, 4'd1, 4'd3, 0, lat, e, ea, ew);
      run_op(OP_ADD, 4'd0, 4'd1, 4'd3, 0, ea, ew);
      dbg_sel = 4'd3; #1;
      checks++;
      if (dbg_data !== v) begin
         errors++;
         $display("FAIL r0_source: R3=%h want %h", dbg_data, v);
      end
   endtask

   task automatic test_mul();
      int lat; bit e; logic [31:0] ea, ew;
      preload(4'd1, 32'hFF);
      preload(4'd2, 32'hFF);
      preload(4'd9, 32'h5A5A);
      model_exec(OP_MUL, 4'd1, 4'd2, 4'd9, 0, lat, e, ea, ew);
      run_op(OP_MUL, 4'd1, 4'd2, 4'd9, 0, ea, ew);
      dbg_sel = 4'd9; #1;
      checks++;
      if (obs_lat !== DATA_W + 4 || dbg_data !== 32'h5A5A) begin
         errors++;
         $display("FAIL mul_timing: latency %0d R9=%h want %0d 00005a5a", obs_lat, dbg_data, DATA_W + 4);
      end
      model_exec(OP_MFHI, 4'd0, 4'd0, 4'd5, 0, lat, e, ea, ew);
      run_op(OP_MFHI, 4'd0, 4'd0, 4'd5, 0, ea, ew);
      model_exec(OP_MFLO, 4'd0, 4'd0, 4'd6, 0, lat, e, ea, ew);
      run_op(OP_MFLO, 4'd0, 4'd0, 4'd6, 0, ea, ew);
      dbg_sel = 4'd5; #1;
      checks++;
      if (dbg_data !== 32'h0) begin
         errors++;
         $display("FAIL mul_ff_hi: R5=%h want 00000000", dbg_data);
      end
      dbg_sel = 4'd6; #1;
      checks++;
      if (dbg_data !== 32'hFE01) begin
         errors++;
         $display("FAIL mul_ff_lo: R6=%h want 0000fe01", dbg_data);
      end
      preload(4'd1, 32'hFFFF_FFFF);
      preload(4'd2, 32'hFFFF_FFFF);
      model_exec(OP_MUL, 4'd1, 4'd2, 4'd0, 0, lat, e, ea, ew);
      run_op(OP_MUL, 4'd1, 4'd2, 4'd0, 0, ea, ew);
      model_exec(OP_MFHI, 4'd0, 4'd0, 4'd5, 0, lat, e, ea, ew);
      run_op(OP_MFHI, 4'd0, 4'd0, 4'd5, 0, ea, ew);
      model_exec(OP_MFLO, 4'd0, 4'd0, 4'd6, 0, lat, e, ea, ew);
      run_op(OP_MFLO, 4'd0, 4'd0, 4'd6, 0, ea, ew);
      dbg_sel = 4'd5; #1;
      checks++;
      if (dbg_data !== 32'hFFFF_FFFE) begin
         errors++;
         $display("FAIL mul_max_hi: R5=%h want fffffffe", dbg_data);
      end
      dbg_sel = 4'd6; #1;
      checks++;
      if (dbg_data !== 32'h0000_0001) begin
         errors++;
         $display("FAIL mul_max_lo: R6=%h want 00000001", dbg_data);
      end
   endtask

   task automatic test_ldst();
      int lat; bit e; logic [31:0] ea, ew;
      preload(4'd1, 32'h10);
      preload(4'd2, 32'h4);
      preload(4'd6, 32'hCAFE);
      model_exec(OP_ST, 4'd1, 4'd2, 4'd6, 3, lat, e, ea, ew);
      run_op(OP_ST, 4'd1, 4'd2, 4'd6, 3, 32'h14, 32'hCAFE);
      checks++;
      if (obs_lat !== 7 || obs_req !== 3 || obs_bad !== 0 || obs_err !== 1'b0) begin
         errors++;
         $display("FAIL st_basic: latency %0d req %0d badcyc %0d err %b want 7 3 0 0",
                  obs_lat, obs_req, obs_bad, obs_err);
      end
      model_exec(OP_LD, 4'd1, 4'd2, 4'd7, 3, lat, e, ea, ew);
      run_op(OP_LD, 4'd1, 4'd2, 4'd7, 3, 32'h14, ew);
      dbg_sel = 4'd7; #1;
      checks++;
      if (dbg_data !== 32'hCAFE || obs_lat !== 8 || obs_bad !== 0) begin
         errors++;
         $display("FAIL ld_basic: R7=%h latency %0d badcyc %0d want 0000cafe 8 0",
                  dbg_data, obs_lat, obs_bad);
      end
   endtask

   task automatic test_timeout();
      int lat; bit e; logic [31:0] ea, ew;
      preload(4'd8, 32'h0BAD_F00D);
      model_exec(OP_LD, 4'd1, 4'd2, 4'd8, 0, lat, e, ea, ew);
      run_op(OP_LD, 4'd1, 4'd2, 4'd8, 0, ea, ew);
      dbg_sel = 4'd8; #1;
      checks++;
      if (obs_req !== 15 || obs_lat !== 19 || obs_err !== 1'b1 || obs_stray !== 0) begin
         errors++;
         $display("FAIL ld_timeout: req %0d latency %0d err %b stray %0d want 15 19 1 0",
                  obs_req, obs_lat, obs_err, obs_stray);
      end
      checks++;
      if (dbg_data !== 32'h0BAD_F00D) begin
         errors++;
         $display("FAIL ld_timeout_nowb: R8=%h want 0badf00d", dbg_data);
      end
      model_exec(OP_ST, 4'd1, 4'd2, 4'd8, 0, lat, e, ea, ew);
      run_op(OP_ST, 4'd1, 4'd2, 4'd8, 0, ea, ew);
      checks++;
      if (obs_req !== 15 || obs_lat !== 19 || obs_err !== 1'b1) begin
         errors++;
         $display("FAIL st_timeout: req %0d latency %0d err %b want 15 19 1", obs_req, obs_lat, obs_err);
      end
      model_exec(OP_LD, 4'd1, 4'd2, 4'd8, 15, lat, e, ea, ew);
      run_op(OP_LD, 4'd1, 4'd2, 4'd8, 15, ea, ew);
      dbg_sel = 4'd8; #1;
      checks++;
      if (obs_err !== 1'b0 || obs_lat !== 20 || dbg_data !== 32'hCAFE) begin
         errors++;
         $display("FAIL ld_ack_at_limit: err %b latency %0d R8=%h want 0 20 0000cafe",
                  obs_err, obs_lat, dbg_data);
      end
   endtask

   task automatic test_random();
      int lat, k, kind, bad;
      bit e;
      logic [31:0] ea, ew;
      logic [2:0] o;
      logic [3:0] a, b, c;
      for (int r = 1; r < 16; r++) preload(4'(r), $urandom);
      for (int it = 0; it < 40; it++) begin
         o = 3'($urandom);
         a = 4'($urandom); b = 4'($urandom); c = 4'($urandom);
         kind = $urandom_range(0, 9);
         k = (kind == 0) ? 0 : (kind == 1) ? 15 : (kind == 2) ? 14 : $urandom_range(1, 5);
         model_exec(o, a, b, c, k, lat, e, ea, ew);
         run_op(o, a, b, c, k, ea, ew);
         checks++;
         if (obs_lat !== lat || obs_err !== e || obs_bad !== 0 || obs_stray !== 0 ||
             obs_busy_after !== 1'b0) begin
            errors++;
            $display("FAIL rand_op%0d: op %0d lat %0d err %b bad %0d stray %0d busy %b want lat %0d err %b",
                     it, o, obs_lat, obs_err, obs_bad, obs_stray, obs_busy_after, lat, e);
         end
         dbg_sel = c; #1;
         checks++;
         if (dbg_data !== m_regs[c]) begin
            errors++;
            $display("FAIL rand_rc%0d: R%0d=%h want %h", it, c, dbg_data, m_regs[c]);
         end
      end
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i); #1;
         if (dbg_data !== m_regs[i]) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rand_regfile: %0d registers differ, want 0", bad);
      end
   endtask

   task automatic test_reset_mid_ld();
      int n, bad;
      int lat; bit e; logic [31:0] ea, ew;
      @(negedge clock);
      start = 1'b1; op = OP_LD; ra = 4'd1; rb = 4'd2; rc = 4'd7;
      @(posedge clock); #1;
      start = 1'b0;
      n = 0;
      while (!mem_rd && n < 20) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (mem_rd !== 1'b1) begin
         errors++;
         $display("FAIL midld_request: mem_rd=%b want 1", mem_rd);
      end
      #2 clear = 1'b0;
      #1;
      checks++;
      if (mem_rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL midld_async: rd %b busy %b done %b err %b want 0 0 0 0", mem_rd, busy, done, err);
      end
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i); #1;
         if (dbg_data !== 32'h0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midld_regs: %0d registers nonzero, want 0", bad);
      end
      @(negedge clock);
      clear = 1'b1;
      model_reset();
      model_exec(OP_MFHI, 4'd0, 4'd0, 4'd3, 0, lat, e, ea, ew);
      run_op(OP_MFHI, 4'd0, 4'd0, 4'd3, 0, ea, ew);
      dbg_sel = 4'd3; #1;
      checks++;
      if (dbg_data !== 32'h0 || obs_lat !== 4) begin
         errors++;
         $display("FAIL midld_hi_cleared: R3=%h latency %0d want 0 4", dbg_data, obs_lat);
      end
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      clear = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
      mem_ack = 1'b0; mem_rdata = '0; dbg_sel = '0;
      model_reset();
      test_reset();
      test_alu();
      test_r0();
      test_mul();
      test_ldst();
      test_timeout();
      test_random();
      test_reset_mid_ld();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
